// File: rtl/spi_mem_pkg.sv
// Purpose : shared types for the SPI/host byte-RAM arbiter (commands, FSM states, pending-op record).
// Latency : n/a (types and one combinational helper only).
// Backpressure: n/a.
// Contents: cmd_e, arb_state_e, src_e, pend_t, addr_wrap_inc().
package spi_mem_pkg;

  localparam int DATA_W = 8;
  localparam int WORD_W = 10;

  // SPI command prefix carried in rx_data[9:8].
  typedef enum logic [1:0] {
    CMD_WR_ADDR = 2'b00,
    CMD_WR_DATA = 2'b01,
    CMD_RD_ADDR = 2'b10,
    CMD_RD_DATA = 2'b11
  } cmd_e;

  typedef enum logic [1:0] {
    IDLE     = 2'd0,
    SPI_ACC  = 2'd1,
    HOST_ACC = 2'd2
  } arb_state_e;

  typedef enum logic {
    SRC_SPI  = 1'b0,
    SRC_HOST = 1'b1
  } src_e;

  // Pending SPI data operation; the address is frozen at capture time.
  typedef struct packed {
    logic              we;
    logic [7:0]        addr;
    logic [DATA_W-1:0] data;
  } pend_t;

  // Next address with wrap from depth-1 back to 0.
  function automatic logic [7:0] addr_wrap_inc(input logic [7:0] addr, input int unsigned depth);
    logic [7:0] last;
    last = 8'(depth - 1);
    return (addr == last) ? 8'h00 : addr + 8'h01;
  endfunction

endpackage

// File: rtl/spi_mem_ram.sv
// Purpose : single-port byte RAM, synchronous write and registered read.
// Latency : read data valid the cycle after re; write takes effect at the clock edge.
// Backpressure: none; one access per cycle, caller owns arbitration.
// Ports   : clk, rst (clears only the read register), we/re, addr, wdata -> rdata.
module spi_mem_ram #(
  parameter int MEM_DEPTH = 256,
  parameter int ADDR_SIZE = 8
) (
  input  logic                 clk,
  input  logic                 rst,
  input  logic                 we,
  input  logic                 re,
  input  logic [ADDR_SIZE-1:0] addr,
  input  logic [7:0]           wdata,
  output logic [7:0]           rdata
);

  logic [7:0] mem [MEM_DEPTH];

  // Array contents are intentionally never reset.
  always_ff @(posedge clk) begin
    if (we) begin
      mem[addr] <= wdata;
    end
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      rdata <= '0;
    end else if (re) begin
      rdata <= mem[addr];
    end
  end

endmodule

// File: rtl/spi_mem_arbiter.sv
// Purpose : decodes SPI command words and shares one byte RAM round-robin between SPI and a host port.
// Latency : SPI read edge N -> tx_valid N+3; host req seen M -> host_gnt M+1 -> host_rvalid M+2.
// Backpressure: 1-entry SPI op buffer; a data op arriving while it is full is dropped and spi_ovf sticks.
// Ports   : clk, rst | rx_data/rx_valid in, tx_data/tx_valid out | host_req/we/addr/wdata in,
//           host_gnt/host_rdata/host_rvalid out | spi_ovf sticky drop flag.
module spi_mem_arbiter
  import spi_mem_pkg::*;
#(
  parameter int MEM_DEPTH = 256,
  parameter int ADDR_SIZE = 8,
  parameter int ADDR_INC  = 0
) (
  input  logic                 clk,
  input  logic                 rst,
  input  logic [WORD_W-1:0]    rx_data,
  input  logic                 rx_valid,
  output logic [DATA_W-1:0]    tx_data,
  output logic                 tx_valid,
  input  logic                 host_req,
  input  logic                 host_we,
  input  logic [ADDR_SIZE-1:0] host_addr,
  input  logic [DATA_W-1:0]    host_wdata,
  output logic                 host_gnt,
  output logic [DATA_W-1:0]    host_rdata,
  output logic                 host_rvalid,
  output logic                 spi_ovf
);

  arb_state_e state, state_nxt;
  src_e       last_grant;
  logic       grant_spi, grant_host;
  logic       spi_acc, host_acc;

  logic       rx_valid_d;
  logic       capture, data_cap, ovf_hit, load_pend;
  cmd_e       cmd;
  logic [7:0] wr_addr, rd_addr;
  pend_t      pend, pend_new;
  logic       pend_vld;

  logic              spi_rd, host_rd;
  logic              tx_resp;
  logic [DATA_W-1:0] tx_data_q;

  logic                 ram_we, ram_re;
  logic [ADDR_SIZE-1:0] ram_addr;
  logic [DATA_W-1:0]    ram_wdata, ram_rdata;

  // ---------------------------------------------------------------- capture
  // rx_valid may be held for several cycles; only its rising edge is a word.
  assign capture  = rx_valid & ~rx_valid_d;
  assign cmd      = cmd_e'(rx_data[9:8]);
  assign data_cap = capture & ((cmd == CMD_WR_DATA) | (cmd == CMD_RD_DATA));
  // The buffer frees up in SPI_ACC, so a capture in that cycle may refill it.
  assign ovf_hit   = data_cap & pend_vld & ~spi_acc;
  assign load_pend = data_cap & ~ovf_hit;

  always_comb begin
    pend_new      = '0;
    pend_new.we   = (cmd == CMD_WR_DATA);
    pend_new.addr = (cmd == CMD_WR_DATA) ? wr_addr : rd_addr;
    pend_new.data = rx_data[7:0];
  end

  // ---------------------------------------------------------------- FSM
  always_ff @(posedge clk) begin
    if (rst) begin
      state      <= IDLE;
      last_grant <= SRC_HOST;   // SPI wins the first tie after reset
    end else begin
      state <= state_nxt;
      if (grant_spi) begin
        last_grant <= SRC_SPI;
      end else if (grant_host) begin
        last_grant <= SRC_HOST;
      end
    end
  end

  always_comb begin
    state_nxt  = state;
    grant_spi  = 1'b0;
    grant_host = 1'b0;
    spi_acc    = 1'b0;
    host_acc   = 1'b0;
    host_gnt   = 1'b0;
    case (state)
      IDLE: begin
        if (pend_vld && host_req) begin
          grant_spi  = (last_grant == SRC_HOST);
          grant_host = (last_grant == SRC_SPI);
        end else begin
          grant_spi  = pend_vld;
          grant_host = host_req;
        end
        if (grant_spi) begin
          state_nxt = SPI_ACC;
        end else if (grant_host) begin
          state_nxt = HOST_ACC;
        end
      end
      SPI_ACC: begin
        spi_acc   = 1'b1;
        state_nxt = IDLE;
      end
      HOST_ACC: begin
        host_acc  = 1'b1;
        host_gnt  = 1'b1;
        state_nxt = IDLE;
      end
      default: state_nxt = IDLE;
    endcase
  end

  // ---------------------------------------------------------------- RAM port
  assign spi_rd  = spi_acc & ~pend.we;
  assign host_rd = host_acc & ~host_we;

  // A write landing on a reset cycle is squashed so reset mid-access leaves memory intact.
  assign ram_we    = ~rst & ((spi_acc & pend.we) | (host_acc & host_we));
  assign ram_re    = spi_rd | host_rd;
  assign ram_addr  = spi_acc ? pend.addr[ADDR_SIZE-1:0] : host_addr;
  assign ram_wdata = spi_acc ? pend.data : host_wdata;

  spi_mem_ram #(
    .MEM_DEPTH (MEM_DEPTH),
    .ADDR_SIZE (ADDR_SIZE)
  ) u_ram (
    .clk   (clk),
    .rst   (rst),
    .we    (ram_we),
    .re    (ram_re),
    .addr  (ram_addr),
    .wdata (ram_wdata),
    .rdata (ram_rdata)
  );

  // ---------------------------------------------------------------- datapath
  always_ff @(posedge clk) begin
    if (rst) begin
      rx_valid_d  <= 1'b0;
      wr_addr     <= '0;
      rd_addr     <= '0;
      pend        <= '0;
      pend_vld    <= 1'b0;
      spi_ovf     <= 1'b0;
      tx_valid    <= 1'b0;
      tx_resp     <= 1'b0;
      tx_data_q   <= '0;
      host_rvalid <= 1'b0;
    end else begin
      rx_valid_d <= rx_valid;

      if (capture) begin
        case (cmd)
          CMD_WR_ADDR: wr_addr <= 8'(rx_data[ADDR_SIZE-1:0]);
          CMD_RD_ADDR: rd_addr <= 8'(rx_data[ADDR_SIZE-1:0]);
          CMD_WR_DATA: if (load_pend && (ADDR_INC != 0)) wr_addr <= addr_wrap_inc(wr_addr, MEM_DEPTH);
          CMD_RD_DATA: if (load_pend && (ADDR_INC != 0)) rd_addr <= addr_wrap_inc(rd_addr, MEM_DEPTH);
        endcase
      end

      if (load_pend) begin
        pend     <= pend_new;
        pend_vld <= 1'b1;
      end else if (spi_acc) begin
        pend_vld <= 1'b0;
      end

      if (ovf_hit) begin
        spi_ovf <= 1'b1;
      end

      // tx_resp marks the cycle the RAM read register holds the SPI byte;
      // tx_data_q keeps it afterwards so tx_data stays stable.
      tx_resp <= spi_rd;
      if (spi_rd) begin
        tx_valid <= 1'b1;
      end else if (capture) begin
        tx_valid <= 1'b0;
      end
      if (tx_resp) begin
        tx_data_q <= ram_rdata;
      end

      host_rvalid <= host_rd;
    end
  end

  assign tx_data    = tx_resp ? ram_rdata : tx_data_q;
  assign host_rdata = ram_rdata;

endmodule

// File: tb/tb_spi_mem_arbiter.sv
module tb_spi_mem_arbiter;

  localparam int MEM_DEPTH = 256;
  localparam int ADDR_SIZE = 8;
  localparam int ADDR_INC  = 1;

  logic                 clk = 1'b0;
  logic                 rst = 1'b1;
  logic [9:0]           rx_data = '0;
  logic                 rx_valid = 1'b0;
  logic [7:0]           tx_data;
  logic                 tx_valid;
  logic                 host_req = 1'b0;
  logic                 host_we = 1'b0;
  logic [ADDR_SIZE-1:0] host_addr = '0;
  logic [7:0]           host_wdata = '0;
  logic                 host_gnt;
  logic [7:0]           host_rdata;
  logic                 host_rvalid;
  logic                 spi_ovf;

  spi_mem_arbiter #(
    .MEM_DEPTH (MEM_DEPTH),
    .ADDR_SIZE (ADDR_SIZE),
    .ADDR_INC  (ADDR_INC)
  ) dut (
    .clk         (clk),
    .rst         (rst),
    .rx_data     (rx_data),
    .rx_valid    (rx_valid),
    .tx_data     (tx_data),
    .tx_valid    (tx_valid),
    .host_req    (host_req),
    .host_we     (host_we),
    .host_addr   (host_addr),
    .host_wdata  (host_wdata),
    .host_gnt    (host_gnt),
    .host_rdata  (host_rdata),
    .host_rvalid (host_rvalid),
    .spi_ovf     (spi_ovf)
  );

  always #5 clk = ~clk;

  int cyc = 0;
  always @(posedge clk) cyc <= cyc + 1;

  int n_checks = 0;
  int n_pass   = 0;

  // Reference model: memory image plus the two SPI address pointers.
  logic [7:0] mem_m [256];
  int         m_wr = 0;
  int         m_rd = 0;
  logic [7:0] exp_tx[$];
  logic [7:0] exp_host[$];

  int   tx_rise_cyc = -1;
  int   host_rv_cyc = -1;
  int   edge_cyc    = 0;
  int   req_cyc     = 0;
  logic tx_valid_prev = 1'b0;

  task automatic check(input string name, input logic [31:0] got, input logic [31:0] exp);
    n_checks++;
    if (got === exp) n_pass++;
    else $display("FAIL %s: got 0x%0h expected 0x%0h", name, got, exp);
  endtask

  task automatic fail_now(input string name);
    n_checks++;
    $display("FAIL %s: event missing or unexpected", name);
  endtask

  // Monitor: pops expected responses whenever the DUT presents one.
  always @(negedge clk) begin
    if (!rst) begin
      if (tx_valid && !tx_valid_prev) begin
        tx_rise_cyc = cyc;
        if (exp_tx.size() == 0) fail_now("tx_unexpected");
        else check("tx_data", 32'(tx_data), 32'(exp_tx.pop_front()));
      end
      if (host_rvalid) begin
        host_rv_cyc = cyc;
        if (exp_host.size() == 0) fail_now("host_rvalid_unexpected");
        else check("host_rdata", 32'(host_rdata), 32'(exp_host.pop_front()));
      end
    end
    tx_valid_prev = tx_valid;
  end

  initial begin
    #1000000;
    $display("FAIL watchdog: time limit reached");
    $fatal(1, "watchdog");
  end

  task automatic model_capture(input logic [1:0] c, input logic [7:0] v);
    case (c)
      2'b00: m_wr = int'(v);
      2'b10: m_rd = int'(v);
      2'b01: begin mem_m[m_wr] = v; m_wr = (m_wr + 1) % MEM_DEPTH; end
      default: begin exp_tx.push_back(mem_m[m_rd]); m_rd = (m_rd + 1) % MEM_DEPTH; end
    endcase
  endtask

  task automatic do_reset();
    rst = 1'b1; host_req = 1'b0; rx_valid = 1'b0;
    repeat (3) @(posedge clk);
    #1 rst = 1'b0;
    m_wr = 0; m_rd = 0;
  endtask

  // Raises rx_valid for a new word and leaves it high.
  task automatic spi_edge(input logic [1:0] c, input logic [7:0] v);
    @(posedge clk); #1;
    rx_data = {c, v}; rx_valid = 1'b1; edge_cyc = cyc;
    model_capture(c, v);
  endtask

  task automatic spi_word(input logic [1:0] c, input logic [7:0] v, input int hold);
    spi_edge(c, v);
    repeat (hold) @(posedge clk);
    #1 rx_valid = 1'b0;
    repeat (9) @(posedge clk);
  endtask

  task automatic host_raise(input logic we, input logic [7:0] a, input logic [7:0] d);
    @(posedge clk); #1;
    host_req = 1'b1; host_we = we; host_addr = a; host_wdata = d; req_cyc = cyc;
    if (we) mem_m[a] = d;
    else exp_host.push_back(mem_m[a]);
  endtask

  task automatic host_wait_drop(output int g);
    g = -1;
    for (int i = 0; i < 20; i++) begin
      @(negedge clk);
      if (host_gnt === 1'b1) begin g = cyc; break; end
    end
    if (g < 0) fail_now("host_gnt_timeout");
    @(posedge clk); #1 host_req = 1'b0;
  endtask

  task automatic host_op(input logic we, input logic [7:0] a, input logic [7:0] d);
    int g;
    host_raise(we, a, d);
    host_wait_drop(g);
  endtask

  task automatic check_outputs_zero(input string tag);
    check({tag, "_tx_valid"},    32'(tx_valid),    32'h0);
    check({tag, "_tx_data"},     32'(tx_data),     32'h0);
    check({tag, "_host_gnt"},    32'(host_gnt),    32'h0);
    check({tag, "_host_rvalid"}, 32'(host_rvalid), 32'h0);
    check({tag, "_host_rdata"},  32'(host_rdata),  32'h0);
    check({tag, "_spi_ovf"},     32'(spi_ovf),     32'h0);
  endtask

  initial begin
    int g;
    int k;
    logic [7:0] old40;

    // Reset state
    do_reset();
    @(negedge clk);
    check_outputs_zero("reset");

    // Fill every location through the host port so the model knows the whole image
    for (int a = 0; a < MEM_DEPTH; a++) host_op(1'b1, 8'(a), 8'($urandom_range(0, 255)));

    // Basic SPI round trip and read latency
    spi_word(2'b00, 8'h12, 1);
    spi_word(2'b01, 8'hA5, 1);
    spi_word(2'b10, 8'h12, 1);
    spi_word(2'b11, 8'h00, 1);
    check("rt_latency", 32'(tx_rise_cyc - edge_cyc), 32'd3);
    check("rt_tx_hold_valid", 32'(tx_valid), 32'd1);
    check("rt_tx_hold_data", 32'(tx_data), 32'hA5);

    // Contention after reset: SPI wins the first tie, host follows two cycles later
    do_reset();
    spi_edge(2'b01, 8'h3C);
    k = edge_cyc;
    host_raise(1'b0, 8'h12, 8'h00);
    rx_valid = 1'b0;
    host_wait_drop(g);
    check("tie1_host_gnt_cycle", 32'(g - k), 32'd4);
    repeat (9) @(posedge clk);

    // Second tie after an SPI grant: host goes first, SPI read completes after it
    spi_word(2'b10, 8'h12, 1);
    spi_word(2'b01, 8'h4D, 1);
    spi_edge(2'b11, 8'h00);
    k = edge_cyc;
    host_raise(1'b0, 8'h00, 8'h00);
    rx_valid = 1'b0;
    host_wait_drop(g);
    check("tie2_host_gnt_cycle", 32'(g - k), 32'd2);
    repeat (8) @(posedge clk);
    check("tie2_spi_after_host", 32'(tx_rise_cyc - k), 32'd5);

    // Auto-increment wrap at the top of memory
    spi_word(2'b00, 8'hFF, 1);
    spi_word(2'b01, 8'h11, 1);
    spi_word(2'b01, 8'h22, 1);
    spi_word(2'b10, 8'hFF, 1);
    spi_word(2'b11, 8'h00, 1);
    spi_word(2'b11, 8'h00, 1);
    check("wrap_second_read", 32'(tx_data), 32'h22);
    host_op(1'b0, 8'hFF, 8'h00);
    host_op(1'b0, 8'h00, 8'h00);

    // rx_valid held three cycles counts as one word
    spi_word(2'b00, 8'h50, 1);
    spi_word(2'b01, 8'h5C, 3);
    check("hold_no_ovf", 32'(spi_ovf), 32'd0);
    spi_word(2'b01, 8'h6D, 1);
    host_op(1'b0, 8'h50, 8'h00);
    host_op(1'b0, 8'h51, 8'h00);
    host_op(1'b0, 8'h52, 8'h00);

    // Overflow: buffer held by a host grant when a second data word arrives
    spi_word(2'b00, 8'h5F, 1);
    spi_word(2'b01, 8'h99, 1);
    spi_edge(2'b01, 8'hA1);
    k = edge_cyc;
    host_raise(1'b0, 8'h33, 8'h00);
    rx_valid = 1'b0;
    @(posedge clk); #1;
    rx_data = {2'b01, 8'hB2}; rx_valid = 1'b1;   // dropped: not fed to the model
    host_wait_drop(g);
    rx_valid = 1'b0;
    check("ovf_host_gnt_cycle", 32'(g - k), 32'd2);
    repeat (10) @(posedge clk);
    check("ovf_flag", 32'(spi_ovf), 32'd1);
    host_op(1'b0, 8'h5F, 8'h00);
    host_op(1'b0, 8'h60, 8'h00);
    host_op(1'b0, 8'h61, 8'h00);
    spi_word(2'b01, 8'hC3, 1);
    host_op(1'b0, 8'h61, 8'h00);
    check("ovf_flag_sticky", 32'(spi_ovf), 32'd1);

    // Leave a read response standing, then reset in the middle of a host write
    spi_word(2'b10, 8'h5F, 1);
    spi_word(2'b11, 8'h00, 1);
    old40 = mem_m[8'h40];
    @(posedge clk); #1;
    host_req = 1'b1; host_we = 1'b1; host_addr = 8'h40; host_wdata = 8'h77;
    g = -1;
    for (int i = 0; i < 20; i++) begin
      @(negedge clk);
      if (host_gnt === 1'b1) begin g = cyc; break; end
    end
    if (g < 0) fail_now("rstop_gnt_timeout");
    rst = 1'b1; host_req = 1'b0;
    @(posedge clk);
    @(negedge clk);
    check_outputs_zero("rstop");
    rst = 1'b0;
    m_wr = 0; m_rd = 0;
    host_raise(1'b0, 8'h40, 8'h00);
    check("rstop_model_kept", 32'(mem_m[8'h40]), 32'(old40));
    host_wait_drop(g);
    check("rstop_idle_gnt_latency", 32'(g - req_cyc), 32'd1);
    repeat (2) @(posedge clk);
    check("host_rvalid_latency", 32'(host_rv_cyc - g), 32'd1);

    // Randomised serial traffic
    for (int n = 0; n < 60; n++) begin
      int r;
      r = $urandom_range(0, 5);
      case (r)
        0: spi_word(2'b00, 8'($urandom_range(0, 255)), $urandom_range(1, 3));
        1: spi_word(2'b01, 8'($urandom_range(0, 255)), $urandom_range(1, 3));
        2: spi_word(2'b10, 8'($urandom_range(0, 255)), $urandom_range(1, 3));
        3: spi_word(2'b11, 8'($urandom_range(0, 255)), $urandom_range(1, 3));
        4: host_op(1'b1, 8'($urandom_range(0, 255)), 8'($urandom_range(0, 255)));
        default: host_op(1'b0, 8'($urandom_range(0, 255)), 8'h00);
      endcase
    end

    repeat (20) @(posedge clk);
    check("tx_queue_drained", 32'(exp_tx.size()), 32'd0);
    check("host_queue_drained", 32'(exp_host.size()), 32'd0);
    check("final_no_ovf", 32'(spi_ovf), 32'd0);

    $display("%0d/%0d checks passed", n_pass, n_checks);
    $finish;
  end

endmodule
